// File: rtl/i2s_pkg.sv
// Shared I2S definitions: receiver FSM states, channel encoding of lrck and
// the default sample width used by both transmitter and receiver.
package i2s_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  localparam logic LEFT_CH  = 1'b0;
  localparam logic RIGHT_CH = 1'b1;

  localparam int DEFAULT_WIDTH = 24;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with a rising-edge
// strobe derived from the synchronized level.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_q    = r_sync[SYNC_STAGES-1];
  assign o_rise = o_q & ~r_prev;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sck/lrck/sdin in the clk domain, assembles
// left/right words and hands complete pairs over a valid/ready interface.
//
// state | meaning
// SYNC  | no frame alignment yet, waiting for lrck 1->0
// LEFT  | assembling left word
// RIGHT | assembling right word, pair published when it completes
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sck,
  input  logic             i_lrck,
  input  logic             i_sdin,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_left,
  output logic [WIDTH-1:0] o_right,
  output logic             o_valid,
  output logic             o_overrun,
  output logic             o_locked
);

  localparam int                CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]     CNT_MAX  = CW'(WIDTH);
  localparam logic [WIDTH-1:0]  MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  logic             w_sck_rise;
  logic             w_sck_q;
  logic             w_lrck;
  logic             w_sdin;
  logic             w_unused_sck_q;
  logic             w_unused_lrck_rise;
  logic             w_unused_sdin_rise;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_lr_prev;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_left_hold;
  logic [WIDTH-1:0] r_right_hold;
  logic             r_pub;

  logic             w_change;
  logic [WIDTH-1:0] w_word;
  logic             w_clear;
  logic             w_latch_left;
  logic             w_latch_right;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_sck),
    .o_q     (w_sck_q),
    .o_rise  (w_sck_rise)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrck (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_lrck),
    .o_q     (w_lrck),
    .o_rise  (w_unused_lrck_rise)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdin (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_sdin),
    .o_q     (w_sdin),
    .o_rise  (w_unused_sdin_rise)
  );

  assign w_unused_sck_q = w_sck_q;

  // A word ends on the sck edge where lrck first reads its new value.
  assign w_change = w_sck_rise & (w_lrck != r_lr_prev);
  assign w_word   = w_sdin ? (r_shift | (MSB_MASK >> r_cnt)) : r_shift;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= SYNC;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (w_change) begin
      case (r_state)
        SYNC:    if ((r_lr_prev == RIGHT_CH) && (w_lrck == LEFT_CH)) w_next_state = LEFT;
        LEFT:    w_next_state = RIGHT;
        RIGHT:   w_next_state = LEFT;
        default: w_next_state = SYNC;
      endcase
    end
  end

  always_comb begin
    w_clear       = (r_state == SYNC) | w_change;
    w_latch_left  = w_change & (r_state == LEFT);
    w_latch_right = w_change & (r_state == RIGHT);
    o_locked      = (r_state != SYNC);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lr_prev    <= 1'b0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_left_hold  <= '0;
      r_right_hold <= '0;
      r_pub        <= 1'b0;
    end else begin
      r_pub <= w_latch_right;
      if (w_sck_rise) begin
        r_lr_prev <= w_lrck;
        if (w_clear) begin
          r_shift <= '0;
          r_cnt   <= '0;
        end else begin
          r_shift <= w_word;
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
        end
        if (w_latch_left)  r_left_hold  <= w_word;
        if (w_latch_right) r_right_hold <= w_word;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_left    <= '0;
      o_right   <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else if (r_pub) begin
      o_left    <= r_left_hold;
      o_right   <= r_right_hold;
      o_valid   <= 1'b1;
      o_overrun <= o_valid & ~i_ready;
    end else begin
      o_overrun <= 1'b0;
      if (o_valid && i_ready) o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: two instances (2 and 3 synchronizer stages) share
// one I2S stream; expected words and latencies are hand-computed constants.
module tb_i2s_rx;

  logic clk = 1'b0;
  logic rst_n, sck, lrck, sdin, ready;
  logic [23:0] left2, right2, left3, right3;
  logic valid2, ovr2, locked2, valid3, ovr3, locked3;

  always #5 clk = ~clk;

  i2s_rx #(.WIDTH(24), .SYNC_STAGES(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sck(sck), .i_lrck(lrck), .i_sdin(sdin),
    .i_ready(ready), .o_left(left2), .o_right(right2), .o_valid(valid2),
    .o_overrun(ovr2), .o_locked(locked2)
  );

  i2s_rx #(.WIDTH(24), .SYNC_STAGES(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sck(sck), .i_lrck(lrck), .i_sdin(sdin),
    .i_ready(ready), .o_left(left3), .o_right(right3), .o_valid(valid3),
    .o_overrun(ovr3), .o_locked(locked3)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic tx_lr, pend, closed;
  int lat2, lat3;

  int          mon_v2 = 0, mon_o2 = 0, mon_olong2 = 0;
  logic        ovr2_prev = 1'b0;
  logic [23:0] mon_l2 = '0, mon_r2 = '0, mon_l3 = '0, mon_r3 = '0;

  always @(negedge clk) begin
    if (valid2) begin
      mon_v2 <= mon_v2 + 1;
      mon_l2 <= left2;
      mon_r2 <= right2;
    end
    if (valid3) begin
      mon_l3 <= left3;
      mon_r3 <= right3;
    end
    if (ovr2) mon_o2 <= mon_o2 + 1;
    if (ovr2 && ovr2_prev) mon_olong2 <= mon_olong2 + 1;
    ovr2_prev <= ovr2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sck_cycle(input logic lr, input logic d);
    sck = 1'b0; lrck = lr; sdin = d;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Data lags lrck by one bit: the first cycle of a word carries the previous LSB.
  task automatic send_word(input logic lr, input logic [31:0] w, input int n);
    int k0;
    k0 = closed ? 1 : 0;
    closed = 1'b0;
    for (int k = k0; k < n; k++) sck_cycle(lr, (k == 0) ? pend : w[n-k]);
    pend  = w[0];
    tx_lr = lr;
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
    send_word(1'b0, l, n);
    send_word(1'b1, r, n);
  endtask

  // Final right bit with lrck back to 0; measures latency, optionally pulses ready.
  task automatic close_pair(input int ready_edge);
    sck = 1'b0; lrck = 1'b0; sdin = pend;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    lat2 = 0; lat3 = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (valid2 && lat2 == 0) lat2 = n;
      if (valid3 && lat3 == 0) lat3 = n;
      if (ready_edge != 0 && n == ready_edge - 1) ready = 1'b1;
      if (ready_edge != 0 && n == ready_edge) ready = 1'b0;
    end
    @(negedge clk);
    tx_lr = 1'b0; closed = 1'b1;
    #1;
  endtask

  int base_v, base_o;

  initial begin
    rst_n = 1'b0; sck = 1'b0; lrck = 1'b0; sdin = 1'b0; ready = 1'b1;
    tx_lr = 1'b0; pend = 1'b0; closed = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_left", {8'h0, left2}, 32'h0);
    check("rst_right", {8'h0, right2}, 32'h0);
    check("rst_valid", {31'h0, valid2}, 32'h0);
    check("rst_overrun", {31'h0, ovr2}, 32'h0);
    check("rst_locked", {31'h0, locked2}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // lock acquisition and basic frame
    send_frame(32'h111111, 32'h222222, 24);
    #1;
    check("no_lock_before_fall", {31'h0, locked2}, 32'h0);
    check("no_pub_in_sync", mon_v2, 0);
    send_frame(32'hA5A5A5, 32'h3C3C3C, 24);
    #1;
    check("locked_s2", {31'h0, locked2}, 32'h1);
    check("locked_s3", {31'h0, locked3}, 32'h1);
    check("no_pub_before_right", mon_v2, 0);
    close_pair(0);
    check("valid_one_clk", mon_v2, 1);
    check("left_a5", {8'h0, mon_l2}, 32'hA5A5A5);
    check("right_3c", {8'h0, mon_r2}, 32'h3C3C3C);
    check("left_a5_s3", {8'h0, mon_l3}, 32'hA5A5A5);
    check("right_3c_s3", {8'h0, mon_r3}, 32'h3C3C3C);
    check("latency_s2", lat2, 4);
    check("latency_s3", lat3, 5);
    check("valid_dropped", {31'h0, valid2}, 32'h0);
    send_frame(32'hA5A5A5, 32'h3C3C3C, 24);
    close_pair(0);
    check("valid_one_clk_2nd", mon_v2, 2);

    // overrun with ready held low
    ready = 1'b0;
    base_o = mon_o2;
    send_frame(32'h000001, 32'h000002, 24);
    close_pair(0);
    check("hold_valid", {31'h0, valid2}, 32'h1);
    check("hold_left", {8'h0, left2}, 32'h1);
    check("hold_right", {8'h0, right2}, 32'h2);
    check("no_overrun_first", mon_o2 - base_o, 0);
    send_frame(32'h000003, 32'h000004, 24);
    close_pair(0);
    check("overrun_pulse", mon_o2 - base_o, 1);
    check("overrun_single_clk", mon_olong2, 0);
    check("ovr_left", {8'h0, left2}, 32'h3);
    check("ovr_right", {8'h0, right2}, 32'h4);
    check("ovr_valid", {31'h0, valid2}, 32'h1);
    ready = 1'b1;
    @(negedge clk); #1;
    check("drain_valid", {31'h0, valid2}, 32'h0);

    // acceptance on the same edge as a new publish
    ready = 1'b0;
    send_frame(32'h000005, 32'h000006, 24);
    close_pair(0);
    check("pend_left", {8'h0, left2}, 32'h5);
    base_o = mon_o2;
    send_frame(32'h000007, 32'h000008, 24);
    close_pair(4);
    check("same_edge_valid", {31'h0, valid2}, 32'h1);
    check("same_edge_left", {8'h0, left2}, 32'h7);
    check("same_edge_right", {8'h0, right2}, 32'h8);
    check("same_edge_no_ovr", mon_o2 - base_o, 0);
    ready = 1'b1;
    @(negedge clk); #1;
    check("same_edge_drain", {31'h0, valid2}, 32'h0);

    // short and long words
    send_frame(32'h0000FFFF, 32'h00008001, 16);
    close_pair(0);
    check("short_left", {8'h0, mon_l2}, 32'hFFFF00);
    check("short_right", {8'h0, mon_r2}, 32'h800100);
    send_frame(32'h12345678, 32'h9ABCDEF0, 32);
    close_pair(0);
    check("long_left", {8'h0, mon_l2}, 32'h123456);
    check("long_right", {8'h0, mon_r2}, 32'h9ABCDE);

    // reset in the middle of a right word
    send_word(1'b0, 32'h777777, 24);
    for (int i = 0; i < 10; i++) sck_cycle(1'b1, i[0]);
    rst_n = 1'b0;
    repeat (2) @(negedge clk); #1;
    check("midrst_locked", {31'h0, locked2}, 32'h0);
    check("midrst_left", {8'h0, left2}, 32'h0);
    check("midrst_valid", {31'h0, valid2}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    base_v = mon_v2;
    for (int i = 0; i < 14; i++) sck_cycle(1'b1, 1'b1);
    pend = 1'b0; tx_lr = 1'b1; closed = 1'b0;
    #1;
    check("relock_wait", {31'h0, locked2}, 32'h0);
    send_frame(32'h0ABCDE, 32'h012345, 24);
    #1;
    check("relock", {31'h0, locked2}, 32'h1);
    check("relock_no_pub", mon_v2 - base_v, 0);
    close_pair(0);
    check("relock_pub_count", mon_v2 - base_v, 1);
    check("relock_left", {8'h0, mon_l2}, 32'h0ABCDE);
    check("relock_right", {8'h0, mon_r2}, 32'h012345);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter WIDTH, default 24, sample width in bits per channel.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flops per serial input (minimum 2).
REQ-003 clk  input  1  system clock; all logic on rising edge; frequency SHALL be at least 4x sck.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 sck  input  1  serial bit clock from external transmitter, asynchronous to clk.
REQ-006 lrck  input  1  word select; 0 = left, 1 = right.
REQ-007 sdin  input  1  serial data, MSB first, I2S format (MSB one sck after lrck change).
REQ-008 left  output  WIDTH  received left sample of current pair.
REQ-009 right  output  WIDTH  received right sample of current pair.
REQ-010 valid  output  1  left/right pair available.
REQ-011 ready  input  1  consumer accepts pair when valid & ready on a clk edge.
REQ-012 overrun  output  1  one-clk pulse: completed pair overwrote an unaccepted pair.
REQ-013 locked  output  1  frame alignment acquired (state not SYNC).

Function
REQ-014 sck, lrck and sdin SHALL each pass through SYNC_STAGES flops; sck rising edge is detected as synced sck = 1 with its previous registered value = 0.
REQ-015 On each detected sck rising edge the block SHALL sample synced lrck and sdin together; no other clk cycle changes the shift register, bit counter or state.
REQ-016 A bit sampled at an sck edge belongs to the channel given by the lrck value sampled at the previous sck edge (I2S one-bit delay).
REQ-017 A word SHALL complete at the sck edge where the sampled lrck differs from the previous sampled lrck; that edge's bit is the word's LSB-side final bit.
REQ-018 Bits SHALL shift in MSB-first; the bit counter saturates at WIDTH; bits beyond WIDTH are discarded; words shorter than WIDTH are left-justified with zero-filled LSBs.
REQ-019 State machine: SYNC -> LEFT on sampled lrck 1->0; LEFT -> RIGHT on lrck 0->1 (left word latched to holding register); RIGHT -> LEFT on lrck 1->0 (right word completes, pair published).
REQ-020 In SYNC, all sampled data SHALL be discarded and no pair published; the first pair published after reset is the first complete left word followed by its right word.
REQ-021 Publishing: left and right outputs update and valid asserts on the clk edge after the sck-edge detection that completes the right word.
REQ-022 valid SHALL remain high with left/right stable until the clk edge where valid & ready, then deassert unless a new pair is published on that same edge.
REQ-023 Publish while valid & ~ready: outputs take the new pair, valid stays high, overrun pulses for exactly one clk.
REQ-024 Publish on the same edge as acceptance (valid & ready): new pair taken, valid stays high, no overrun.
REQ-025 left and right SHALL never change while valid is high except per REQ-023/REQ-024.
REQ-026 End-to-end latency from sck pin rising edge (final right bit) to valid high: SYNC_STAGES + 2 clk cycles.

Reset
REQ-027 While rst is low: state = SYNC, left = 0, right = 0, valid = 0, overrun = 0, locked = 0, shift register, bit counter, holding register and synchronizer flops all 0.
REQ-028 Reset asserted mid-word or mid-pair SHALL discard partial data; after release the block re-acquires per REQ-020.

Structure
REQ-029 Shared package i2s_pkg SHALL hold the state enumeration (SYNC, LEFT, RIGHT), channel constants (LEFT_CH = 0, RIGHT_CH = 1) and the default sample width constant shared with the transmitter.
REQ-030 One sub-module, sync_edge, SHALL implement the SYNC_STAGES synchronizer plus rising-edge detect; instantiated for sck, plain synchronizer use for lrck and sdin.

Verification
REQ-031 WIDTH=24, clk = 8x sck, I2S frames left 0xA5A5A5, right 0x3C3C3C, ready tied high -> first full pair after lock reads left 0xA5A5A5 / right 0x3C3C3C, valid one clk per frame.
REQ-032 Reset released while lrck = 1 mid-right word -> no pair published until the following left/right words complete; locked rises on first lrck 1->0.
REQ-033 ready low across two frames (0x000001/0x000002, then 0x000003/0x000004) -> overrun single-clk pulse at second publish; outputs read 0x000003/0x000004.
REQ-034 16-bit words 0xFFFF/0x8001 into WIDTH=24 -> left 0xFFFF00, right 0x800100; 32-bit words 0x12345678/0x9ABCDEF0 -> 0x123456/0x9ABCDE.
REQ-035 ready asserted on exactly the edge a new pair publishes -> valid stays high, overrun stays 0, new pair visible.
REQ-036 Measure sck pin edge of final right bit to valid rise -> exactly SYNC_STAGES + 2 clk for SYNC_STAGES = 2 and 3.
